// File: rtl/wb_irq_ctrl_if.sv
// Wishbone slave bundle carrying the register-bank accesses of wb_irq_ctrl.
interface wb_irq_ctrl_if;
    logic        i_wb_stb;
    logic        i_wb_cyc;
    logic        i_wb_we;
    logic [31:0] i_wb_addr;
    logic [31:0] i_wb_data;
    logic [3:0]  i_wb_sel;
    logic [2:0]  i_wb_cti;
    logic        o_wb_ack;
    logic        o_wb_err;
    logic [31:0] o_wb_data;

    modport slave (
        input  i_wb_stb, i_wb_cyc, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel, i_wb_cti,
        output o_wb_ack, o_wb_err, o_wb_data
    );

    modport master (
        output i_wb_stb, i_wb_cyc, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel, i_wb_cti,
        input  o_wb_ack, o_wb_err, o_wb_data
    );
endinterface

// File: rtl/wb_irq_ctrl.sv
// Claim/complete interrupt controller with per-source level or rising-edge triggering,
// lowest-index priority and a Wishbone register bank (PENDING, ENABLE, CLAIM, EDGE).
module wb_irq_ctrl #(
    parameter int unsigned WB_REGISTERED = 0,
    parameter int unsigned NUM_SRC       = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    wb_irq_ctrl_if.slave       wb,
    input  logic [NUM_SRC-1:0] i_irq,
    output logic               o_ext_int
);
    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_ENABLE  = 2'd1;
    localparam logic [1:0] REG_CLAIM   = 2'd2;
    localparam logic [1:0] REG_EDGE    = 2'd3;

    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] inservice_q, inservice_d;
    logic [NUM_SRC-1:0] edge_q, edge_d;
    logic [NUM_SRC-1:0] irq_prev_q;
    logic               ext_int_q;
    logic               ack_q, err_q;
    logic [31:0]        data_q;

    logic [1:0]         reg_sel;
    logic               wb_error, accept, do_read, do_write;
    logic               reg_start;
    logic [NUM_SRC-1:0] set_vec, active, claim_hot, complete_hot;
    logic [31:0]        claim_id, rdata;

    assign reg_sel  = wb.i_wb_addr[3:2];
    assign wb_error = wb.i_wb_stb &&
                      (wb.i_wb_addr[1:0] != 2'b00 || (wb.i_wb_we && reg_sel == REG_PENDING));

    // Registered mode starts a response only when the previous cycle carried none.
    assign reg_start = wb.i_wb_stb && !ack_q && !err_q;
    assign accept    = (WB_REGISTERED != 0) ? (reg_start && !wb_error)
                                            : (wb.i_wb_stb && !wb_error && !i_rst);
    assign do_read   = accept && !wb.i_wb_we;
    assign do_write  = accept && wb.i_wb_we;

    // Level sources request while high; edge sources only on a 0->1 transition.
    assign set_vec = ~inservice_q & i_irq & (~edge_q | ~irq_prev_q);
    assign active  = pending_q & enable_q;

    always_comb begin
        claim_id  = '0;
        claim_hot = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                claim_id     = 32'(i + 1);
                claim_hot    = '0;
                claim_hot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        complete_hot = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            complete_hot[i] = (wb.i_wb_data == 32'(i + 1));
        end
    end

    always_comb begin
        rdata = '0;
        unique case (reg_sel)
            REG_PENDING: rdata = 32'(pending_q);
            REG_ENABLE:  rdata = 32'(enable_q);
            REG_CLAIM:   rdata = claim_id;
            REG_EDGE:    rdata = 32'(edge_q);
            default:     rdata = '0;
        endcase
    end

    always_comb begin
        pending_d   = pending_q | set_vec;
        inservice_d = inservice_q;
        enable_d    = enable_q;
        edge_d      = edge_q;
        // Claim wins over a same-cycle set: the source is in service from now on.
        if (do_read && reg_sel == REG_CLAIM) begin
            pending_d   = pending_d & ~claim_hot;
            inservice_d = inservice_q | claim_hot;
        end
        if (do_write) begin
            case (reg_sel)
                REG_ENABLE: enable_d    = wb.i_wb_data[NUM_SRC-1:0];
                REG_CLAIM:  inservice_d = inservice_q & ~complete_hot;
                REG_EDGE:   edge_d      = wb.i_wb_data[NUM_SRC-1:0];
                default:    ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pending_q   <= '0;
            enable_q    <= '0;
            inservice_q <= '0;
            edge_q      <= '0;
            irq_prev_q  <= '0;
            ext_int_q   <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            data_q      <= '0;
        end else begin
            pending_q   <= pending_d;
            enable_q    <= enable_d;
            inservice_q <= inservice_d;
            edge_q      <= edge_d;
            irq_prev_q  <= i_irq;
            ext_int_q   <= |active;
            ack_q       <= reg_start && !wb_error;
            err_q       <= reg_start && wb_error;
            data_q      <= do_read ? rdata : '0;
        end
    end

    assign o_ext_int    = ext_int_q;
    assign wb.o_wb_ack  = (WB_REGISTERED != 0) ? ack_q  : (wb.i_wb_stb && !wb_error && !i_rst);
    assign wb.o_wb_err  = (WB_REGISTERED != 0) ? err_q  : (wb_error && !i_rst);
    assign wb.o_wb_data = (WB_REGISTERED != 0) ? data_q : rdata;

    logic unused_wb;
    assign unused_wb = ^{wb.i_wb_cyc, wb.i_wb_sel, wb.i_wb_cti, wb.i_wb_addr[31:4]};
endmodule
